// File: rtl/mac_mul_negator_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_mul_negator_pipe_if
// Purpose  : Stream bundle (config, operands, results, handshakes) for the
//            MAC sign-magnitude converter.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_mul_negator_pipe_if #(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int NUM_LANES      = 4,
  parameter int MAC_CONF_WIDTH = 4
) ();
  logic                                en;
  logic [MAC_CONF_WIDTH-1:0]           cfg;
  logic                                in_valid;
  logic                                in_ready;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0]  A_in;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0]  B_in;
  logic                                out_valid;
  logic                                out_ready;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0]  A_out;
  logic [NUM_LANES*MAC_MIN_WIDTH-1:0]  B_out;
  logic [NUM_LANES-1:0]                C_neg;
  logic [MAC_CONF_WIDTH-1:0]           cfg_out;

  modport master (
    output en, cfg, in_valid, A_in, B_in, out_ready,
    input  in_ready, out_valid, A_out, B_out, C_neg, cfg_out
  );

  modport slave (
    input  en, cfg, in_valid, A_in, B_in, out_ready,
    output in_ready, out_valid, A_out, B_out, C_neg, cfg_out
  );
endinterface
`default_nettype wire

// File: rtl/mac_mul_negator_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_mul_negator_pipe
// Purpose  : Two-stage valid/ready pipeline that groups packed lanes, turns
//            negative signed groups into magnitudes and flags product sign.
// Revision : 1.0 - initial release
// ============================================================================
module mac_mul_negator_pipe #(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int NUM_LANES      = 4,
  parameter int MODE_WIDTH     = 2,
  parameter int MAC_CONF_WIDTH = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  mac_mul_negator_pipe_if.slave  bus
);

  localparam int c_data_w     = NUM_LANES * MAC_MIN_WIDTH;
  localparam int c_lane_idx_w = $clog2(NUM_LANES);

  // Handshake
  logic                         w_adv1;
  logic                         w_adv2;

  // Stage-1 grouping / sign decode
  logic                         w_signed;
  logic [MODE_WIDTH-1:0]        w_mode;
  logic [c_lane_idx_w-1:0]      w_gm1;
  logic [c_lane_idx_w-1:0]      w_top [NUM_LANES];
  logic [NUM_LANES-1:0]         w_a_msb;
  logic [NUM_LANES-1:0]         w_b_msb;
  logic [NUM_LANES-1:0]         w_bnd;
  logic [NUM_LANES-1:0]         w_neg_a;
  logic [NUM_LANES-1:0]         w_neg_b;

  // Stage-1 registers
  logic                         r_s1_valid;
  logic [c_data_w-1:0]          r_s1_a;
  logic [c_data_w-1:0]          r_s1_b;
  logic [MAC_CONF_WIDTH-1:0]    r_s1_cfg;
  logic [NUM_LANES-1:0]         r_s1_neg_a;
  logic [NUM_LANES-1:0]         r_s1_neg_b;
  logic [NUM_LANES-1:0]         r_s1_bnd;

  // Stage-2 negation results and registers
  logic [c_data_w-1:0]          w_mag_a;
  logic [c_data_w-1:0]          w_mag_b;
  logic                         r_s2_valid;
  logic [c_data_w-1:0]          r_a_out;
  logic [c_data_w-1:0]          r_b_out;
  logic [NUM_LANES-1:0]         r_c_neg;
  logic [MAC_CONF_WIDTH-1:0]    r_cfg_out;

  // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
  assign w_adv2 = bus.en & (~r_s2_valid | bus.out_ready);
  assign w_adv1 = bus.en & (~r_s1_valid | w_adv2);

  assign w_signed = bus.cfg[MAC_CONF_WIDTH-1];
  assign w_mode   = bus.cfg[MODE_WIDTH-1:0];

  // Group size minus one as a lane-index mask; oversize modes fall back to single.
  always_comb begin
    w_gm1 = '0;
    if (int'(w_mode) <= c_lane_idx_w) begin
      for (int k = 0; k < c_lane_idx_w; k++) begin
        if (k < int'(w_mode)) begin
          w_gm1[k] = 1'b1;
        end
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [c_lane_idx_w-1:0] c_lane = c_lane_idx_w'(l);

    assign w_a_msb[l] = bus.A_in[l*MAC_MIN_WIDTH + MAC_MIN_WIDTH-1];
    assign w_b_msb[l] = bus.B_in[l*MAC_MIN_WIDTH + MAC_MIN_WIDTH-1];
    assign w_top[l]   = c_lane | w_gm1;
    assign w_bnd[l]   = ((c_lane & w_gm1) == '0);
    assign w_neg_a[l] = w_signed & w_a_msb[w_top[l]];
    assign w_neg_b[l] = w_signed & w_b_msb[w_top[l]];
  end

  // Invert then add one through a lane-wide carry chain that restarts at each group.
  function automatic logic [c_data_w-1:0] f_negate(
    input logic [c_data_w-1:0]  data,
    input logic [NUM_LANES-1:0] neg,
    input logic [NUM_LANES-1:0] bnd
  );
    logic [c_data_w-1:0]      res;
    logic [MAC_MIN_WIDTH-1:0] x;
    logic                     carry;
    res   = '0;
    carry = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      x = data[l*MAC_MIN_WIDTH +: MAC_MIN_WIDTH] ^ {MAC_MIN_WIDTH{neg[l]}};
      if (bnd[l]) begin
        carry = neg[l];
      end
      res[l*MAC_MIN_WIDTH +: MAC_MIN_WIDTH] = x + {{(MAC_MIN_WIDTH-1){1'b0}}, carry};
      carry = carry & (&x);
    end
    return res;
  endfunction

  assign w_mag_a = f_negate(r_s1_a, r_s1_neg_a, r_s1_bnd);
  assign w_mag_b = f_negate(r_s1_b, r_s1_neg_b, r_s1_bnd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cfg   <= '0;
      r_s1_neg_a <= '0;
      r_s1_neg_b <= '0;
      r_s1_bnd   <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_a     <= bus.A_in;
        r_s1_b     <= bus.B_in;
        r_s1_cfg   <= bus.cfg;
        r_s1_neg_a <= w_neg_a;
        r_s1_neg_b <= w_neg_b;
        r_s1_bnd   <= w_bnd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_a_out    <= '0;
      r_b_out    <= '0;
      r_c_neg    <= '0;
      r_cfg_out  <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_a_out   <= w_mag_a;
        r_b_out   <= w_mag_b;
        r_c_neg   <= r_s1_neg_a ^ r_s1_neg_b;
        r_cfg_out <= r_s1_cfg;
      end
    end
  end

  // Held low while reset is asserted so nothing is offered as accepted.
  assign bus.in_ready  = w_adv1 & rst;
  assign bus.out_valid = r_s2_valid;
  assign bus.A_out     = r_a_out;
  assign bus.B_out     = r_b_out;
  assign bus.C_neg     = r_c_neg;
  assign bus.cfg_out   = r_cfg_out;

endmodule
`default_nettype wire

// File: doc/mac_mul_negator_pipe.md
Name: mac_mul_negator_pipe

Overview:
- Parametrised, pipelined sign-magnitude converter placed in front of the MAC multiplier array.
- Takes NUM_LANES packed lanes of A and B operands and groups them into 1, 2, 4… lane-wide operands according to cfg.
- In signed mode, replaces each negative group with its two's-complement magnitude and reports the product sign for each lane.
- Adds valid/ready flow control and a 2-stage pipeline.

Parameters:
- MAC_MIN_WIDTH, 8, bits per lane.
- NUM_LANES, 4, lane count; power of 2, ≥2.
- MODE_WIDTH, 2, width of the grouping field cfg[MODE_WIDTH-1:0].
- MAC_CONF_WIDTH, 4, cfg width; bit MAC_CONF_WIDTH-1 selects signed(1)/unsigned(0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  pipeline enable; 0 freezes all state.
- cfg  in  MAC_CONF_WIDTH  mode; sampled with each accepted transaction.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  input accepted this cycle when in_valid & in_ready.
- A_in  in  NUM_LANES*MAC_MIN_WIDTH  packed A lanes; lane 0 is LSBs.
- B_in  in  NUM_LANES*MAC_MIN_WIDTH  packed B lanes.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- A_out  out  NUM_LANES*MAC_MIN_WIDTH  A magnitudes.
- B_out  out  NUM_LANES*MAC_MIN_WIDTH  B magnitudes.
- C_neg  out  NUM_LANES  per-lane product-negative flag.
- cfg_out  out  MAC_CONF_WIDTH  cfg travelling with the data.

Behaviour:
- Reset (rst=0, async):
  - s1_valid, s2_valid, out_valid, in_ready all clear.
  - A_out, B_out, C_neg, cfg_out = 0.
  - Takes effect immediately mid-operation; in-flight transactions are discarded.
- Grouping:
  - m = cfg[MODE_WIDTH-1:0]; group size G = 2^m.
  - If 2^m > NUM_LANES, treat as m=0 (single).
  - Groups are contiguous: lanes kG..kG+G-1, lowest lane least significant.
- Sign per group:
  - sA = MSB of the top lane of the group; sB likewise.
  - C_neg lanes of group = signed & (sA ^ sB), replicated across the group; all 0 when unsigned.
- Negation:
  - If signed & sA, the group's A becomes (~A + 1) mod 2^(G*MAC_MIN_WIDTH); otherwise A passes unchanged. Same rule for B.
  - Implemented as a per-lane +1 carry chain; carry into a lane is 1 at each group boundary, otherwise the previous lane's carry-out.
  - Most-negative value maps to itself, e.g. 0x80 -> 0x80, read as unsigned magnitude 128; no overflow flag.
- Pipeline:
  - S1 registers the inputs, cfg, group signs and select bits.
  - S2 registers the negated data, C_neg and cfg.
  - Latency is exactly 2 cycles from acceptance to out_valid with no stalls.
  - adv2 = en & (~s2_valid | out_ready); adv1 = en & (~s1_valid | adv2).
  - in_ready = adv1, combinational; it may depend on out_ready.
  - The S2 load is the S1 contents when adv2; s2_valid clears when adv2 & ~s1_valid.
  - Throughput is 1 per cycle when out_ready stays high.
- Stall:
  - out_valid with out_ready=0 holds A_out/B_out/C_neg/cfg_out stable.
  - Up to 2 transactions are buffered; in_ready deasserts when both stages are full and out_ready=0.
- en=0:
  - in_ready=0; no stage advances.
  - Outputs and out_valid hold; a handshake does not complete even if out_ready=1.
- Simultaneous events: accept and emit in the same cycle are permitted.
- Ordering: strict FIFO order; no transaction is dropped or duplicated.
- cfg may change every transaction; each result uses its own captured cfg.

Test Plan:
- Single mode, signed (cfg=4'b1000), A_in=0x7FFF0180, B_in=0x02020202 -> 2 cycles later A_out=0x7F010180, B_out=0x02020202, C_neg=4'b0101.
- Dual mode, signed (cfg=4'b1001), A_in=0x80000001, B_in=0xFFFF0002 -> A_out=0x80000001, B_out=0x00010002, C_neg=4'b0000.
- Quad mode, signed (cfg=4'b1010), A_in=0xFFFFFFFF, B_in=0x00000003 -> A_out=0x00000001, B_out=0x00000003, C_neg=4'b1111.
- Unsigned (cfg=4'b0010, then reserved m=3 cfg=4'b0011), A_in=0xFFFFFFFF -> passes unchanged, C_neg=0; reserved-mode signed check (cfg=4'b1011) behaves as single: A_in=0xFF000000 -> 0x01000000.
- Backpressure and en:
  - Stimulus: 4 back-to-back transactions; out_ready low for 5 cycles; en low for 2 cycles mid-stream.
  - Response: in_ready drops after 2 are held and outputs stay stable; all 4 emerge in order, 1 per cycle, once out_ready=1.
- Reset mid-stream: pulse rst low with both stages valid -> out_valid=0 and outputs 0 immediately (asynchronously); the first transaction after release has 2-cycle latency.
